// File: rtl/field_mem_pkg.sv
// Shared types and default widths for the field RAM arbiter and its read-tag pipeline.
package field_mem_pkg;

  localparam int FIELD_DATAW_DEF = 96;
  localparam int ADDRW_DEF       = 12;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_SOL  = 2'd2
  } owner_e;

  typedef enum logic {
    DISP_PRI  = 1'b0,
    SOL_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/field_rd_tag_pipe.sv
// Owner-tag shift register; the last stage names who owns the RAM read data arriving this cycle.
module field_rd_tag_pipe
  import field_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   reset_n,
  input  owner_e tag_i,
  output owner_e exit_owner_o
);

  owner_e tag_q [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= OWN_NONE;
    end else begin
      tag_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign exit_owner_o = tag_q[DEPTH-1];

endmodule

// File: rtl/field_mem_arbiter.sv
// Arbitrates the single-port field RAM between display fetch and the fluid solver.
// Build option FIELD_ARB_STARVE_GUARD_EN adds the solver starvation counter and SOL_FORCE state.
//
// state     | meaning
// DISP_PRI  | display wins any cycle it requests; solver takes idle slots
// SOL_FORCE | one-cycle solver-only slot after STARVE_MAX consecutive denials
module field_mem_arbiter
  import field_mem_pkg::*;
#(
  parameter int FIELD_DATAW = FIELD_DATAW_DEF,
  parameter int ADDRW       = ADDRW_DEF,
  parameter int RD_LAT      = 1,
  parameter int STARVE_MAX  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   disp_req,
  input  logic [ADDRW-1:0]       disp_addr,
  output logic                   disp_gnt,
  output logic                   disp_rvalid,
  output logic [FIELD_DATAW-1:0] disp_rdata,
  input  logic                   sol_req,
  input  logic                   sol_we,
  input  logic [ADDRW-1:0]       sol_addr,
  input  logic [FIELD_DATAW-1:0] sol_wdata,
  output logic                   sol_gnt,
  output logic                   sol_rvalid,
  output logic [FIELD_DATAW-1:0] sol_rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDRW-1:0]       mem_addr,
  output logic [FIELD_DATAW-1:0] mem_wdata,
  input  logic [FIELD_DATAW-1:0] mem_rdata
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("field_mem_arbiter: RD_LAT out of range 1..4");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("field_mem_arbiter: STARVE_MAX out of range 1..255");
  end

`ifdef FIELD_ARB_STARVE_GUARD_EN
  localparam logic [7:0] STARVE_MAX_C = 8'(STARVE_MAX);

  arb_state_e state_q, state_d;
  logic [7:0] starve_cnt_q, starve_cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= DISP_PRI;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    disp_gnt     = 1'b0;
    sol_gnt      = 1'b0;
    state_d      = DISP_PRI;
    starve_cnt_d = starve_cnt_q;
    unique case (state_q)
      DISP_PRI: begin
        disp_gnt = disp_req;
        sol_gnt  = sol_req & ~disp_req;
      end
      SOL_FORCE: sol_gnt = sol_req;
      default: ;
    endcase
    // Grants stay low while reset is asserted, even with requests pending.
    disp_gnt = disp_gnt & reset_n;
    sol_gnt  = sol_gnt & reset_n;
    if (!sol_req || sol_gnt) starve_cnt_d = '0;
    else if (starve_cnt_q != STARVE_MAX_C) starve_cnt_d = starve_cnt_q + 8'd1;
    // Switching on the next count makes the forced slot land on the denial that hits the limit.
    if (state_q == DISP_PRI && starve_cnt_d == STARVE_MAX_C) state_d = SOL_FORCE;
  end
`else
  always_comb begin
    disp_gnt = reset_n & disp_req;
    sol_gnt  = reset_n & sol_req & ~disp_req;
  end
`endif

  logic   disp_xfer, sol_xfer;
  owner_e tag_in, exit_owner;

  assign disp_xfer = disp_req & disp_gnt;
  assign sol_xfer  = sol_req & sol_gnt;
  assign tag_in    = disp_xfer             ? OWN_DISP :
                     (sol_xfer && !sol_we) ? OWN_SOL  : OWN_NONE;

  logic                   mem_en_q, mem_we_q;
  logic [ADDRW-1:0]       mem_addr_q;
  logic [FIELD_DATAW-1:0] mem_wdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q <= disp_xfer | sol_xfer;
      mem_we_q <= sol_xfer & sol_we;
      if (disp_xfer) begin
        mem_addr_q <= disp_addr;
      end else if (sol_xfer) begin
        mem_addr_q  <= sol_addr;
        mem_wdata_q <= sol_wdata;
      end
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  field_rd_tag_pipe #(
    .DEPTH(RD_LAT + 1)
  ) u_tag_pipe (
    .clk         (clk),
    .reset_n     (reset_n),
    .tag_i       (tag_in),
    .exit_owner_o(exit_owner)
  );

  logic                   disp_rvalid_q, sol_rvalid_q;
  logic [FIELD_DATAW-1:0] disp_rdata_q, sol_rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_rvalid_q <= 1'b0;
      sol_rvalid_q  <= 1'b0;
      disp_rdata_q  <= '0;
      sol_rdata_q   <= '0;
    end else begin
      disp_rvalid_q <= (exit_owner == OWN_DISP);
      sol_rvalid_q  <= (exit_owner == OWN_SOL);
      if (exit_owner == OWN_DISP) disp_rdata_q <= mem_rdata;
      if (exit_owner == OWN_SOL)  sol_rdata_q  <= mem_rdata;
    end
  end

  assign disp_rvalid = disp_rvalid_q;
  assign sol_rvalid  = sol_rvalid_q;
  assign disp_rdata  = disp_rdata_q;
  assign sol_rdata   = sol_rdata_q;

endmodule

// File: doc/field_mem_arbiter.md
# field_mem_arbiter

Shares the single-port fluid field RAM between the VGA display fetch path (read-only, frame-deadline traffic) and the fluid solver (read/write). Sits between the field RAM and its two requesters. Accepts at most one access per cycle under a valid/grant handshake, registers the RAM command, and routes returning read data to the owning requester with a tag pipeline. Display has fixed priority; a build-time starvation guard bounds solver wait.

## Interface
- FIELD_DATAW, 96, field word width (bits)
- ADDRW, 12, field RAM address width
- RD_LAT, 1, RAM read latency in cycles from the edge sampling mem_en to valid mem_rdata; legal 1..4
- STARVE_MAX, 8, consecutive denied solver cycles before a forced solver slot; legal 1..255

Ports:
- clk  in  1  system clock; one clock, no other clock domains
- reset_n  in  1  asynchronous, active-low reset
- disp_req  in  1  display access request; held with disp_addr stable until granted
- disp_addr  in  ADDRW  display read address
- disp_gnt  out  1  display request accepted this cycle
- disp_rvalid  out  1  disp_rdata valid, one-cycle pulse
- disp_rdata  out  FIELD_DATAW  display read data
- sol_req  in  1  solver access request; held with sol_we/addr/wdata stable until granted
- sol_we  in  1  1 = write, 0 = read
- sol_addr  in  ADDRW  solver address
- sol_wdata  in  FIELD_DATAW  solver write data
- sol_gnt  out  1  solver request accepted this cycle
- sol_rvalid  out  1  sol_rdata valid, one-cycle pulse
- sol_rdata  out  FIELD_DATAW  solver read data
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDRW  RAM address
- mem_wdata  out  FIELD_DATAW  RAM write data
- mem_rdata  in  FIELD_DATAW  RAM read data

## Operation
- Handshake: transfer occurs in a cycle where req && gnt. gnt is combinational from req, state and starvation counter. Deasserting req before grant is legal and cancels the request.
- FSM, two states:
  - DISP_PRI (reset state): display wins whenever disp_req; otherwise solver granted if sol_req.
  - SOL_FORCE: entered when starve_cnt reaches STARVE_MAX. sol_gnt = sol_req and disp_gnt = 0. Returns to DISP_PRI after one cycle, regardless of grant.
- starve_cnt, 8-bit: increments on sol_req && !sol_gnt, saturates at STARVE_MAX. Clears on sol_gnt or !sol_req.
- Command register: on a transfer, mem_en = 1 and mem_we/addr/wdata are loaded next cycle. Idle cycles drive mem_en = 0, mem_we = 0, and hold addr/wdata. Display transfers always have mem_we = 0.
- Tag pipeline: a depth RD_LAT+1 shift register of owner tags (NONE/DISP/SOL). A read transfer inserts an owner tag; writes and idle cycles insert NONE.
- At pipeline exit, mem_rdata is registered into the owner's rdata and its rvalid pulses. The non-owner's rdata holds its last value.
- Read data returns in request order. No reordering and no backpressure on read returns.

## Timing
- Reset values: all gnt, rvalid, mem_en, mem_we = 0; addr, wdata, rdata = 0; state = DISP_PRI; starve_cnt = 0; all tags NONE.
- Throughput: one transfer per cycle, back-to-back across either requester.
- Latency, transfer at edge N to mem_en high: cycle N+1.
- Latency, read transfer to rvalid: RD_LAT+2 cycles (3 at default).
- Write: committed at the edge ending cycle N+1; a read of the same address granted at N+1 returns the new data.
- Simultaneous requests: display granted, except in SOL_FORCE.
- Reset mid-operation: in-flight reads are dropped and produce no rvalid after reset release. Requesters must reissue them.

## Configuration
- FIELD_ARB_STARVE_GUARD_EN defined: starve_cnt and the SOL_FORCE state are present as described.
- Undefined: strict display priority. The FSM stays in DISP_PRI, no counter is built, and STARVE_MAX is ignored.

## Structure
- Package field_mem_pkg:
  - default FIELD_DATAW/ADDRW constants
  - typedef enum owner_e {OWN_NONE, OWN_DISP, OWN_SOL}
  - typedef enum arb_state_e {DISP_PRI, SOL_FORCE}
- Sub-module field_rd_tag_pipe, parameterised by depth: shifts owner_e tags and flags the exit owner.

## Test plan
- Display only, disp_req held for 16 cycles over addresses 0..15, RAM preloaded with addr*3 → disp_gnt every cycle; disp_rvalid every cycle from cycle 3, with data 0,3,…,45 in order.
- Solver write 0xABC to addr 5, then solver read of addr 5 next cycle → sol_rvalid 3 cycles after the read grant, with data 0xABC.
- Both requesting continuously, guard enabled, STARVE_MAX = 8 → sol_gnt once per 9 cycles, display granted in the other 8.
- Same stimulus, guard disabled → sol_gnt never asserts while disp_req is high.
- Interleaved display/solver reads on alternate cycles → each rvalid pulses only on its owner's port, and the non-owner's rdata is unchanged.
- reset_n low for 2 cycles while 2 reads are in flight → no rvalid after release; all outputs 0 during reset.
